dmem_arbiter: RTL and testbench

- Shares the single-port, byte-addressed data memory between the pipeline MEM stage (CPU) and a debug/program-loader port (DBG).
- Issues one memory access at a time and tracks read latency.
- Returns read data to the correct requester.
- Drives a stall to the pipeline hazard logic while a CPU access is blocked or outstanding.
- Sits between the EX/MEM pipeline register and the data memory.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/arb_starve_ctr.sv | 28 ++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory arbiter.
// Request bundle, FSM state and read-owner encodings.
package mem_pkg;

  localparam int NUM_BYTE_LANES = 4;
  localparam int PKG_ADDR_W     = 32;
  localparam int PKG_DATA_W     = 32;

  typedef struct packed {
    logic                      we;
    logic [PKG_ADDR_W-1:0]     addr;
    logic [PKG_DATA_W-1:0]     wdata;
    logic [NUM_BYTE_LANES-1:0] be;
  } mem_req_t;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive blocked debug cycles.
// prio rises once the debug port has waited MAX_WAIT cycles.
module arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic prio
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !req || gnt) begin
      cnt <= '0;
    end else if (cnt != CMAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign prio = (cnt == CMAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the MEM stage and the debug port.
// One access at a time; loads hold the port for MEM_LAT cycles.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = PKG_ADDR_W,
  parameter int DATA_W   = PKG_DATA_W,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [3:0]        dbg_be,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  arb_state_t state_q, state_d;
  owner_t     owner_q, owner_d;
  logic [2:0] lat_q, lat_d;

  mem_req_t cpu_f, dbg_f, win_f;
  logic     cpu_win, dbg_win, rd_done;
  logic     dbg_prio;

  arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clock(clock),
    .reset(reset),
    .req  (dbg_req),
    .gnt  (dbg_gnt),
    .prio (dbg_prio)
  );

  always_comb begin
    cpu_f.we    = cpu_we;
    cpu_f.addr  = cpu_addr;
    cpu_f.wdata = cpu_wdata;
    cpu_f.be    = cpu_be;
    dbg_f.we    = dbg_we;
    dbg_f.addr  = dbg_addr;
    dbg_f.wdata = dbg_wdata;
    dbg_f.be    = dbg_be;
  end

  // Grants and rvalid are masked in reset so an aborted read never returns.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    rd_done = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          dbg_win = dbg_req && (!cpu_req || dbg_prio);
          cpu_win = cpu_req && !dbg_win;
          if ((cpu_win && !cpu_we) || (dbg_win && !dbg_we)) begin
            state_d = RD_WAIT;
            owner_d = dbg_win ? OWN_DBG : OWN_CPU;
            lat_d   = LAT_INIT;
          end
        end
        RD_WAIT: begin
          if (lat_q == 3'd0) begin
            rd_done = 1'b1;
            state_d = IDLE;
          end else begin
            lat_d = lat_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
    end
  end

  assign win_f   = dbg_win ? dbg_f : cpu_f;
  assign cpu_gnt = cpu_win;
  assign dbg_gnt = dbg_win;

  assign mem_req   = cpu_win || dbg_win;
  assign mem_we    = mem_req && win_f.we;
  assign mem_addr  = mem_req ? win_f.addr : '0;
  assign mem_wdata = mem_req ? win_f.wdata : '0;
  assign mem_be    = mem_req ? win_f.be : '0;

  assign cpu_rvalid = rd_done && (owner_q == OWN_CPU);
  assign dbg_rvalid = rd_done && (owner_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

  // Drops in the rvalid cycle so MEM/WB captures the load data.
  assign cpu_stall = (cpu_req && !cpu_gnt)
                   || ((state_q == RD_WAIT)
                       && (owner_q == OWN_CPU)
                       && !cpu_rvalid);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps then random traffic,
// every cycle compared against a transaction-level model.
module tb_dmem_arbiter;

  localparam int MEM_LAT  = 2;
  localparam int MAX_WAIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_be;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MEM_LAT (MEM_LAT),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_be    (dbg_be),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  // Byte-addressed data memory with a fixed read pipeline.
  logic [7:0]  dm [0:1023] = '{default: 8'h00};
  logic [31:0] rp [0:MEM_LAT-1];

  function automatic logic [31:0] dm_word(logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = dm[int'((a + 32'(i)) & 32'h3FF)];
    return w;
  endfunction

  always @(posedge clock) begin
    if (mem_req && mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) dm[int'((mem_addr + 32'(i)) & 32'h3FF)] <= mem_wdata[8*i +: 8];
    end
    rp[0] <= (mem_req && !mem_we) ? dm_word(mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < MEM_LAT; i++) rp[i] <= rp[i-1];
  end

  assign mem_rdata = rp[MEM_LAT-1];

  // Reference model state: cycles left on the in-flight read, etc.
  int          m_busy  = 0;
  int          m_owner = 0;
  int          m_wait  = 0;
  logic [31:0] m_data  = '0;
  logic [7:0]  ref_mem [0:1023] = '{default: 8'h00};

  int checks = 0;
  int passes = 0;

  logic        s_cg, s_dg, s_cv, s_dv, s_stall;
  logic [31:0] s_cd, s_dd;

  function automatic logic [31:0] ref_word(logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[int'((a + 32'(i)) & 32'h3FF)];
    return w;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cycle();
    logic        eg_c, eg_d, ev_c, ev_d, e_stall, e_mreq;
    logic        w_we;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_be;
    #3;
    eg_c = 1'b0; eg_d = 1'b0; ev_c = 1'b0; ev_d = 1'b0;
    if (!reset) begin
      if (m_busy == 0) begin
        eg_d = dbg_req && (!cpu_req || m_wait >= MAX_WAIT);
        eg_c = cpu_req && !eg_d;
      end else if (m_busy == 1) begin
        ev_c = (m_owner == 0);
        ev_d = (m_owner == 1);
      end
    end
    e_stall = (cpu_req && !eg_c) || (m_busy > 0 && m_owner == 0 && !ev_c);
    e_mreq  = eg_c || eg_d;
    w_we    = eg_d ? dbg_we    : cpu_we;
    w_addr  = eg_d ? dbg_addr  : cpu_addr;
    w_wdata = eg_d ? dbg_wdata : cpu_wdata;
    w_be    = eg_d ? dbg_be    : cpu_be;
    chk("cpu_gnt", cpu_gnt, eg_c);
    chk("dbg_gnt", dbg_gnt, eg_d);
    chk("cpu_rvalid", cpu_rvalid, ev_c);
    chk("dbg_rvalid", dbg_rvalid, ev_d);
    chk("cpu_rdata", cpu_rdata, ev_c ? m_data : 32'h0);
    chk("dbg_rdata", dbg_rdata, ev_d ? m_data : 32'h0);
    chk("cpu_stall", cpu_stall, e_stall);
    chk("mem_req", mem_req, e_mreq);
    if (e_mreq) begin
      chk("mem_we", mem_we, w_we);
      chk("mem_addr", mem_addr, w_addr);
      chk("mem_be", {28'h0, mem_be}, {28'h0, w_be});
      if (w_we) chk("mem_wdata", mem_wdata, w_wdata);
    end else begin
      chk("mem_we_idle", mem_we, 1'b0);
    end
    s_cg = cpu_gnt; s_dg = dbg_gnt; s_cv = cpu_rvalid; s_dv = dbg_rvalid;
    s_cd = cpu_rdata; s_dd = dbg_rdata; s_stall = cpu_stall;
    @(posedge clock);
    if (reset) begin
      m_busy = 0;
      m_wait = 0;
    end else begin
      m_wait = (dbg_req && !eg_d) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      if (m_busy > 0) m_busy--;
      if (e_mreq) begin
        if (w_we) begin
          for (int i = 0; i < 4; i++)
            if (w_be[i]) ref_mem[int'((w_addr + 32'(i)) & 32'h3FF)] = w_wdata[8*i +: 8];
        end else begin
          m_busy  = MEM_LAT;
          m_owner = eg_d ? 1 : 0;
          m_data  = ref_word(w_addr);
        end
      end
    end
    #1;
  endtask

  task automatic set_cpu(logic r, logic we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
  endtask

  task automatic set_dbg(logic r, logic we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_be = be;
  endtask

  initial begin
    reset = 1'b1;
    set_cpu(0, 0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    cycle();
    chk("rst_stall_idle", s_stall, 1'b0);
    set_cpu(1, 1, 32'd100, 32'h00FF01FF, 4'hF);
    cycle();
    chk("rst_stall_req", s_stall, 1'b1);
    reset = 1'b0;

    // CPU store
    cycle();
    chk("st_gnt", s_cg, 1'b1);
    chk("st_stall", s_stall, 1'b0);
    set_cpu(0, 0, 0, 0, 0);
    chk("dm100", {24'h0, dm[100]}, 32'hFF);
    chk("dm101", {24'h0, dm[101]}, 32'h01);
    chk("dm102", {24'h0, dm[102]}, 32'hFF);
    chk("dm103", {24'h0, dm[103]}, 32'h00);

    // CPU load
    set_cpu(1, 0, 32'd100, 0, 4'hF);
    cycle();
    chk("ld_gnt", s_cg, 1'b1);
    set_cpu(0, 0, 0, 0, 0);
    cycle();
    chk("ld_stall_t1", s_stall, 1'b1);
    cycle();
    chk("ld_rvalid", s_cv, 1'b1);
    chk("ld_rdata", s_cd, 32'h00FF01FF);
    chk("ld_stall_t2", s_stall, 1'b0);

    // Both ports streaming writes
    set_cpu(1, 1, 32'h200, 32'h11111111, 4'hF);
    set_dbg(1, 1, 32'h300, 32'h22222222, 4'hF);
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("starve_dbg", s_dg, (k == 4 || k == 9));
      chk("starve_cpu", s_cg, !(k == 4 || k == 9));
    end
    set_cpu(0, 0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);
    cycle();

    // Debug read in flight, CPU arrives
    set_dbg(1, 0, 32'd100, 0, 4'hF);
    cycle();
    chk("dr_gnt", s_dg, 1'b1);
    set_dbg(0, 0, 0, 0, 0);
    set_cpu(1, 1, 32'h40, 32'hA5A5A5A5, 4'hF);
    cycle();
    chk("dr_cpu_blk1", s_cg, 1'b0);
    chk("dr_stall1", s_stall, 1'b1);
    cycle();
    chk("dr_rvalid", s_dv, 1'b1);
    chk("dr_rdata", s_dd, 32'h00FF01FF);
    chk("dr_cpu_rv", s_cv, 1'b0);
    chk("dr_stall2", s_stall, 1'b1);
    cycle();
    chk("dr_cpu_gnt", s_cg, 1'b1);
    set_cpu(0, 0, 0, 0, 0);

    // Reset during a read
    set_cpu(1, 0, 32'd100, 0, 4'hF);
    cycle();
    set_cpu(0, 0, 0, 0, 0);
    cycle();
    reset = 1'b1;
    cycle();
    chk("rr_no_rv", s_cv, 1'b0);
    reset = 1'b0;
    cycle();
    chk("rr_no_rv2", s_cv, 1'b0);
    set_cpu(1, 0, 32'd100, 0, 4'hF);
    cycle();
    chk("rr_gnt", s_cg, 1'b1);
    set_cpu(0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("rr_rvalid", s_cv, 1'b1);
    chk("rr_rdata", s_cd, 32'h00FF01FF);

    // Back-to-back CPU writes
    set_cpu(1, 1, 32'h40, 32'h01020304, 4'hF);
    cycle();
    chk("bb_gnt0", s_cg, 1'b1);
    chk("bb_stall0", s_stall, 1'b0);
    set_cpu(1, 1, 32'h44, 32'h05060708, 4'h3);
    cycle();
    chk("bb_gnt1", s_cg, 1'b1);
    chk("bb_stall1", s_stall, 1'b0);
    set_cpu(0, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      cycle();
      if (cpu_req && s_cg) begin
        if ($urandom_range(0, 1) == 0) set_cpu(0, 0, 0, 0, 0);
        else set_cpu(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                     $urandom, 4'($urandom_range(0, 15)));
      end else if (cpu_req && $urandom_range(0, 15) == 0) begin
        set_cpu(0, 0, 0, 0, 0);
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        set_cpu(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                $urandom, 4'($urandom_range(0, 15)));
      end
      if (dbg_req && s_dg) begin
        if ($urandom_range(0, 1) == 0) set_dbg(0, 0, 0, 0, 0);
        else set_dbg(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                     $urandom, 4'($urandom_range(0, 15)));
      end else if (dbg_req && $urandom_range(0, 15) == 0) begin
        set_dbg(0, 0, 0, 0, 0);
      end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        set_dbg(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                $urandom, 4'($urandom_range(0, 15)));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
